// File: rtl/mem_access.sv
// mem_access: pipeline MEM stage that issues one data-bus transaction per load/store,
// aligns and extends load data, and retires ALU ops in a single cycle.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        flush,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_op,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [31:0] reg_dest_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] mem_data_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] reg_dest_out,
    output logic        valid_out,
    output logic        stall_out,
    output logic        misalign_exc
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t      state_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q, reg_q;
    logic        we_q, kill_q;
    logic        is_mem, is_byte, is_half, misalign, live, accept;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, load_d;
    logic [7:0]  byte_l;
    logic [15:0] half_l;
    always_comb begin
        is_mem   = mem_read || mem_write;
        is_byte  = mem_op[1:0] == 2'b00;
        is_half  = mem_op[1:0] == 2'b01;
        misalign = is_half ? alu_result_in[0] : (!is_byte && alu_result_in[1:0] != 2'b00);
        live     = state_q == IDLE && valid_in && !flush;
        accept   = live && is_mem && !misalign;
        be_d     = is_byte ? 4'b0001 << alu_result_in[1:0] :
                   is_half ? (alu_result_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_d  = !mem_write ? 32'h0 :
                   is_byte ? {4{store_data_in[7:0]}} :
                   is_half ? {2{store_data_in[15:0]}} : store_data_in;
        byte_l   = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_l   = dmem_rdata[{addr_q[1], 4'b0000} +: 16];
        // op_q[2] selects zero-extension for the unsigned byte/half codes
        load_d   = op_q[1:0] == 2'b00 ? {{24{!op_q[2] && byte_l[7]}}, byte_l} :
                   op_q[1:0] == 2'b01 ? {{16{!op_q[2] && half_l[15]}}, half_l} : dmem_rdata;
    end
    assign stall_out = !rst && (accept || state_q == WAIT);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            op_q           <= '0;
            addr_q         <= '0;
            reg_q          <= '0;
            we_q           <= 1'b0;
            kill_q         <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_be        <= '0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            mem_data_out   <= '0;
            alu_result_out <= '0;
            reg_dest_out   <= '0;
            valid_out      <= 1'b0;
            misalign_exc   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_out    <= live && !is_mem;
                    misalign_exc <= live && is_mem && misalign;
                    if (accept) begin
                        state_q    <= WAIT;
                        op_q       <= mem_op;
                        addr_q     <= alu_result_in;
                        reg_q      <= reg_dest_in;
                        we_q       <= mem_write;
                        kill_q     <= 1'b0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_be    <= be_d;
                        dmem_addr  <= {alu_result_in[31:2], 2'b00};
                        dmem_wdata <= wdata_d;
                    end else if (live && is_mem) begin
                        alu_result_out <= alu_result_in;
                        reg_dest_out   <= '0;
                    end else if (live) begin
                        alu_result_out <= alu_result_in;
                        reg_dest_out   <= reg_dest_in;
                        mem_data_out   <= '0;
                    end
                end
                WAIT: begin
                    // a flush here only suppresses retirement; the bus cycle still completes
                    kill_q <= kill_q || flush;
                    if (dmem_ack) begin
                        state_q        <= DONE;
                        dmem_req       <= 1'b0;
                        dmem_we        <= 1'b0;
                        mem_data_out   <= we_q ? 32'h0 : load_d;
                        alu_result_out <= addr_q;
                        reg_dest_out   <= reg_q;
                        valid_out      <= !(kill_q || flush);
                    end
                end
                default: begin
                    valid_out <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors with hand-computed expectations for mem_access.
module tb_mem_access;
    logic        clk = 0, rst = 1, valid_in = 0, flush = 0, mem_read = 0, mem_write = 0;
    logic [2:0]  mem_op = 0;
    logic [31:0] alu_result_in = 0, store_data_in = 0, reg_dest_in = 0, dmem_rdata = 0;
    logic        dmem_ack = 0;
    logic        dmem_req, dmem_we, valid_out, stall_out, misalign_exc;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, mem_data_out, alu_result_out, reg_dest_out;
    int          n_vec = 0, n_err = 0, stalls;
    logic        req_w, we_w;
    logic [3:0]  be_w;
    logic [31:0] addr_w, wdata_w;

    mem_access dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .mem_read(mem_read),
        .mem_write(mem_write), .mem_op(mem_op), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .reg_dest_in(reg_dest_in), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_data_out(mem_data_out),
        .alu_result_out(alu_result_out), .reg_dest_out(reg_dest_out), .valid_out(valid_out),
        .stall_out(stall_out), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] sd);
        valid_in = 1; mem_read = rd; mem_write = wr; mem_op = op;
        alu_result_in = a; store_data_in = sd; reg_dest_in = 32'd7;
    endtask

    // accept a memory op, capture the first WAIT-cycle bus, ack after dly extra WAIT cycles; ends in DONE
    task automatic run_mem(input logic rd, input logic wr, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rdv, input int dly);
        set_op(rd, wr, op, a, sd);
        stalls = 0;
        #1 if (stall_out) stalls++;
        tick();
        req_w = dmem_req; we_w = dmem_we; be_w = dmem_be; addr_w = dmem_addr; wdata_w = dmem_wdata;
        for (int i = 0; i <= dly; i++) begin
            if (stall_out) stalls++;
            dmem_ack = (i == dly);
            dmem_rdata = rdv;
            tick();
        end
        dmem_ack = 0;
    endtask

    task automatic retire(input string tag, input logic [31:0] data, input logic [31:0] addr);
        check({tag, " valid"}, valid_out, 1);
        check({tag, " data"}, mem_data_out, data);
        check({tag, " alu"}, alu_result_out, addr);
        check({tag, " dest"}, reg_dest_out, 7);
        check({tag, " req_drop"}, dmem_req, 0);
        check({tag, " stall_done"}, stall_out, 0);
        valid_in = 0;
        tick();
        check({tag, " single"}, valid_out, 0);
    endtask

    initial begin
        set_op(1, 0, 3'b010, 32'h100, 0);
        #1 check("rst stall", stall_out, 0);
        tick(); tick();
        check("rst req", dmem_req, 0);
        check("rst be", dmem_be, 0);
        check("rst valid", valid_out, 0);
        check("rst alu", alu_result_out, 0);
        check("rst data", mem_data_out, 0);
        check("rst exc", misalign_exc, 0);
        valid_in = 0; rst = 0;
        tick();

        run_mem(1, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 0);
        check("lbu req", req_w, 1);
        check("lbu we", we_w, 0);
        check("lbu addr", addr_w, 32'h100);
        check("lbu stalls", stalls, 2);
        retire("lbu", 32'h00000080, 32'h103);
        check("idle hold data", mem_data_out, 32'h00000080);

        run_mem(1, 0, 3'b001, 32'h102, 0, 32'h80FF1234, 2);
        check("lh stalls", stalls, 4);
        retire("lh", 32'hFFFF80FF, 32'h102);

        run_mem(1, 0, 3'b000, 32'h102, 0, 32'h80FF1234, 0);
        retire("lb", 32'hFFFFFFFF, 32'h102);
        run_mem(1, 0, 3'b101, 32'h100, 0, 32'h80FF9234, 1);
        retire("lhu", 32'h00009234, 32'h100);

        run_mem(0, 1, 3'b000, 32'h21, 32'h000000AB, 32'hFFFFFFFF, 0);
        check("sb we", we_w, 1);
        check("sb be", be_w, 4'b0010);
        check("sb wdata", wdata_w, 32'hABABABAB);
        check("sb addr", addr_w, 32'h20);
        retire("sb", 0, 32'h21);

        run_mem(1, 1, 3'b101, 32'h2, 32'h1234CDEF, 32'hFFFFFFFF, 0);
        check("sh we", we_w, 1);
        check("sh be", be_w, 4'b1100);
        check("sh wdata", wdata_w, 32'hCDEFCDEF);
        retire("sh", 0, 32'h2);
        run_mem(0, 1, 3'b010, 32'h40, 32'h11223344, 0, 0);
        check("sw be", be_w, 4'b1111);
        check("sw wdata", wdata_w, 32'h11223344);
        retire("sw", 0, 32'h40);

        set_op(1, 0, 3'b010, 32'h102, 0);
        #1 check("mis stall", stall_out, 0);
        tick();
        check("mis req", dmem_req, 0);
        check("mis exc", misalign_exc, 1);
        check("mis alu", alu_result_out, 32'h102);
        check("mis valid", valid_out, 0);
        check("mis dest", reg_dest_out, 0);
        valid_in = 0;
        tick();
        check("mis pulse", misalign_exc, 0);
        set_op(0, 1, 3'b001, 32'h1, 0);
        tick();
        check("mis sh exc", misalign_exc, 1);
        check("mis sh req", dmem_req, 0);
        valid_in = 0;
        tick();

        set_op(0, 0, 3'b000, 32'h55, 0);
        reg_dest_in = 3;
        #1 check("alu stall", stall_out, 0);
        tick();
        check("alu valid", valid_out, 1);
        check("alu res", alu_result_out, 32'h55);
        check("alu dest", reg_dest_out, 3);
        check("alu data", mem_data_out, 0);
        check("alu req", dmem_req, 0);
        set_op(1, 0, 3'b010, 32'h200, 0);
        #1 check("b2b stall", stall_out, 1);
        tick();
        check("b2b wait valid", valid_out, 0);
        check("b2b req", dmem_req, 1);
        dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
        tick();
        dmem_ack = 0;
        retire("b2b", 32'hDEADBEEF, 32'h200);

        set_op(1, 0, 3'b010, 32'h300, 0);
        tick();
        flush = 1; dmem_ack = 1; dmem_rdata = 32'h12345678;
        tick();
        flush = 0; dmem_ack = 0;
        check("flw valid", valid_out, 0);
        check("flw req", dmem_req, 0);
        valid_in = 0;
        tick();
        check("flw idle", valid_out, 0);

        set_op(1, 0, 3'b010, 32'h400, 0);
        flush = 1;
        #1 check("fli stall", stall_out, 0);
        tick();
        flush = 0; valid_in = 0;
        check("fli valid", valid_out, 0);
        check("fli req", dmem_req, 0);
        dmem_ack = 1;
        tick();
        dmem_ack = 0;
        check("ack idle valid", valid_out, 0);
        check("ack idle alu", alu_result_out, 32'h300);

        set_op(1, 0, 3'b010, 32'h500, 0);
        tick();
        check("rw req", dmem_req, 1);
        rst = 1;
        #1 check("rw stall", stall_out, 0);
        tick();
        rst = 0; valid_in = 0;
        check("rw req drop", dmem_req, 0);
        check("rw addr", dmem_addr, 0);
        check("rw alu", alu_result_out, 0);
        dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_ack = 0;
        check("rw late valid", valid_out, 0);
        check("rw late data", mem_data_out, 0);
        check("rw late stall", stall_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
